// File: rtl/uart_tx_fifo.sv
// UART transmitter with run-time baud divisor, data width, parity and stop bits, fed by an input FIFO.
// Frame settings are captured when a word is popped, so config changes only affect later frames.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        tx,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [4:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        tx_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        nbits_q, nbits_d;
    logic [4:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              stop_idx_q, stop_idx_d;
    logic              tx_d, tx_done_d, busy_d, din_ready_d;
    logic [LVL_W-1:0]  level_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop, bit_end;
    logic [4:0]        nbits_cfg;

    function automatic logic [4:0] clamp_bits(input logic [4:0] b);
        if (b < 5'd5)
            return 5'd5;
        if (b > 5'(DATA_W))
            return 5'(DATA_W);
        return b;
    endfunction

    function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic [4:0] n,
                                         input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < DATA_W; i++)
            if (5'(i) < n)
                p ^= d[i];
        return p;
    endfunction

    assign push      = din_valid & din_ready;
    assign bit_end   = (cnt_q == div_q);
    assign nbits_cfg = clamp_bits(cfg_data_bits);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_level != '0)
                    pop = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == nbits_q - 5'd1) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    cnt_d      = '0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop2_q && !stop_idx_q)
                        stop_idx_d = 1'b1;
                    else if (fifo_level != '0)
                        pop = 1'b1;
                    else
                        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Popping starts a new frame straight away and snapshots the frame format.
        if (pop) begin
            state_d    = START;
            cnt_d      = '0;
            tx_d       = 1'b0;
            shreg_d    = mem[rd_ptr];
            div_d      = cfg_div;
            nbits_d    = nbits_cfg;
            par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit_d  = calc_parity(mem[rd_ptr], nbits_cfg, cfg_parity == 2'b10);
            stop2_d    = cfg_stop2;
            stop_idx_d = 1'b0;
        end

        level_d     = fifo_level + LVL_W'(push) - LVL_W'(pop);
        din_ready_d = (level_d < LVL_W'(FIFO_DEPTH));
        busy_d      = (state_d != IDLE) || (level_d != '0);
        // Registered pulse: raised when the next cycle is the final clock of the last stop bit.
        tx_done_d   = (state_d == STOP) && (cnt_d == div_d) && (stop_idx_d || !stop2_d);
    end

    // NOTE: FIFO storage is not reset; the pointers and level alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            nbits_q    <= 5'd5;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            busy       <= 1'b0;
            din_ready  <= 1'b1;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx         <= tx_d;
            tx_done    <= tx_done_d;
            busy       <= busy_d;
            din_ready  <= din_ready_d;
            fifo_level <= level_d;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized traffic against
// a per-clock line-waveform model built from the frame rules.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        tx;
    logic [15:0] cfg_div = '0;
    logic [4:0]  cfg_data_bits = 5'd8;
    logic [1:0]  cfg_parity = '0;
    logic        cfg_stop2 = 1'b0;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        tx_done;

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .tx(tx), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .busy(busy), .fifo_level(fifo_level), .tx_done(tx_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    logic [7:0] mq[$];   // words waiting in the FIFO
    bit         wave[$]; // line level for each remaining clock of the frame in flight

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_bit(input bit b, input int per);
        for (int k = 0; k < per; k++)
            wave.push_back(b);
    endtask

    task automatic build_frame(input logic [7:0] w);
        int n, per, ones;
        n = (cfg_data_bits < 5'd5) ? 5 : ((cfg_data_bits > 5'd8) ? 8 : int'(cfg_data_bits));
        per = int'(cfg_div) + 1;
        ones = 0;
        push_bit(1'b0, per);
        for (int i = 0; i < n; i++) begin
            push_bit(w[i], per);
            ones += int'(w[i]);
        end
        if (cfg_parity == 2'b01 || cfg_parity == 2'b10)
            push_bit(((ones % 2) == 1) ^ (cfg_parity == 2'b10), per);
        push_bit(1'b1, per);
        if (cfg_stop2)
            push_bit(1'b1, per);
    endtask

    task automatic tick();
        bit ready_m;
        if (din_valid && din_ready === 1'b1 && !reset)
            acc_cnt++;
        @(posedge clock);
        cyc++;
        if (reset) begin
            mq.delete();
            wave.delete();
        end else begin
            ready_m = (mq.size() < DEPTH);
            if (wave.size() > 0)
                void'(wave.pop_front());
            if (wave.size() == 0 && mq.size() > 0)
                build_frame(mq.pop_front());
            if (din_valid && ready_m)
                mq.push_back(din);
        end
        #1;
        if (tx_done === 1'b1)
            done_cnt++;
        check("tx", tx, (wave.size() > 0) ? wave[0] : 1'b1);
        check("tx_done", tx_done, wave.size() == 1);
        check("fifo_level", fifo_level, mq.size());
        check("din_ready", din_ready, mq.size() < DEPTH);
        check("busy", busy, (wave.size() > 0) || (mq.size() > 0));
    endtask

    task automatic run_until_done(input int limit, output int waited);
        waited = 0;
        while (tx_done !== 1'b1 && waited < limit) begin
            tick();
            waited++;
        end
        if (tx_done !== 1'b1)
            check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        if (busy !== 1'b0)
            check("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit stop2);
        cfg_div       = 16'(div);
        cfg_data_bits = 5'(bits);
        cfg_parity    = 2'(par);
        cfg_stop2     = stop2;
    endtask

    task automatic push_one(input logic [7:0] w);
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    initial begin
        int w, a0, d0;
        logic [10:0] seq;

        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_ready", din_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_done", tx_done, 1'b0);
        reset = 1'b0;
        tick();

        // 8N1, div 3: one-cycle latency, 40-clock frame, busy drops after tx_done.
        set_cfg(3, 8, 0, 1'b0);
        push_one(8'h55);
        check("latency_pre", tx, 1'b1);
        tick();
        check("latency_low", tx, 1'b0);
        run_until_done(200, w);
        check("len_8n1", w + 1, 40);
        tick();
        check("busy_drop", busy, 1'b0);

        // 8E1 / 8O1, div 0, 0xA7: start, data LSB first, parity, stop.
        set_cfg(0, 8, 1, 1'b0);
        push_one(8'hA7);
        seq = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            seq = {seq[9:0], tx};
        end
        check("seq_8e1", seq, 11'b01110010111);
        check("done_8e1", tx_done, 1'b1);
        tick();
        check("idle_8e1", busy, 1'b0);

        set_cfg(0, 8, 2, 1'b0);
        push_one(8'hA7);
        seq = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            seq = {seq[9:0], tx};
        end
        check("seq_8o1", seq, 11'b01110010101);
        drain(50);

        // 7O2, div 1, 0xFF: 22 clocks; then 3 data bits clamps to 5 -> 14 clocks.
        set_cfg(1, 7, 2, 1'b1);
        push_one(8'hFF);
        tick();
        run_until_done(100, w);
        check("len_7o2", w + 1, 22);
        drain(50);
        set_cfg(1, 3, 0, 1'b0);
        push_one(8'hFF);
        tick();
        run_until_done(100, w);
        check("len_clamp5", w + 1, 14);
        drain(50);

        // FIFO fill: din_valid held for 8 cycles accepts 5 words, all sent back to back.
        set_cfg(15, 8, 0, 1'b0);
        a0 = acc_cnt;
        d0 = done_cnt;
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'($urandom);
            tick();
        end
        din_valid = 1'b0;
        check("accepted", acc_cnt - a0, 5);
        check("full_ready", din_ready, 1'b0);
        check("full_level", fifo_level, 3'd4);
        drain(2000);
        check("done_pulses", done_cnt - d0, 5);

        // Mid-frame config change only affects the following frame.
        set_cfg(2, 8, 0, 1'b0);
        push_one(8'h3C);
        push_one(8'hC3);
        repeat (5) tick();
        set_cfg(0, 8, 1, 1'b1);
        run_until_done(200, w);
        tick();
        run_until_done(200, w);
        check("len_newcfg", w + 1, 12);
        drain(100);

        // Reset in the middle of DATA with 3 words queued.
        set_cfg(3, 8, 0, 1'b0);
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'($urandom);
            tick();
        end
        din_valid = 1'b0;
        check("queued3", fifo_level, 3'd3);
        repeat (6) tick();
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_level", fifo_level, 3'd0);
        check("mid_rst_ready", din_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        repeat (50) tick();
        check("mid_rst_no_done", done_cnt - d0, 0);

        // Randomized traffic and configuration.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)));
            din_valid = ($urandom_range(0, 99) < 30);
            din = 8'($urandom);
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;
        din_valid = 1'b0;
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter. Replaces the fixed baud table with a run-time clock divisor. Adds run-time selection of data width, parity (none/even/odd) and stop bits (1 or 2), plus an input FIFO so back-to-back frames go out with no idle gap. Sits between the CSR/bus side and the tx pad.

Parameters:
DATA_W, 8, maximum data bits per frame (5..16)
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2
DIV_W, 16, width of baud divisor

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
din  input  DATA_W  transmit word; bit 0 is sent first
din_valid  input  1  din is valid
din_ready  output  1  FIFO can accept a word
tx  output  1  serial line; idles high
cfg_div  input  DIV_W  bit period = cfg_div+1 clocks
cfg_data_bits  input  5  data bits per frame; clamped to 5..DATA_W
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  1 = two stop bits
busy  output  1  FSM not IDLE or FIFO not empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  words held in FIFO
tx_done  output  1  one-cycle pulse at the end of each frame

Behaviour:
- All outputs are registered.
- Reset values: tx=1, din_ready=1, busy=0, fifo_level=0, tx_done=0. The FIFO is flushed and the FSM is in IDLE.
- Reset mid-frame aborts the frame; tx returns to 1 on the next cycle.
- Push: occurs on din_valid & din_ready.
  - din_ready = (fifo_level < FIFO_DEPTH), computed from the registered level.
  - A same-cycle pop does not raise din_ready.
  - With push and pop in the same cycle, the level is unchanged.
  - No overflow or underflow is possible.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: when the FIFO is non-empty.
  - Pop the head word.
  - Latch cfg_div, clamped cfg_data_bits, cfg_parity and cfg_stop2 into frame registers.
  - Drive tx=0.
  - Config changes mid-frame do not affect the frame in flight.
- Latency: a word pushed at edge E into an empty FIFO with an IDLE FSM drives tx low from edge E+1.
- Bit timing: every bit (start, data, parity, each stop) holds tx for exactly cfg_div+1 clocks.
  - A baud counter counts 0..div and rolls over at div.
  - cfg_div=0 gives one clock per bit.
- START -> DATA.
- DATA sends N = clamped cfg_data_bits bits, LSB first. Bits above N-1 are ignored.
- DATA -> PARITY if parity is enabled, else -> STOP.
- Parity bit:
  - even = XOR of the N data bits, so the total count of ones including the parity bit is even;
  - odd = inverse of even.
- STOP sends tx=1 for 1 or 2 bit periods.
- On the final clock of the last stop bit, tx_done pulses for 1 cycle. Then:
  - if the FIFO is non-empty: pop, latch config, go to START (next start bit begins on the following clock, no gap);
  - else: go to IDLE.
- busy=1 from the cycle after a push until the cycle after the final tx_done with the FIFO empty.
- Frame length in clocks = (cfg_div+1) * (1 + N + P + S), where P = 0/1 and S = 1/2.

Test Plan:
- DATA_W=8, cfg_div=3, 8N1, push 0x55 -> tx low 1 cycle after push. Then tx carries 0,1,0,1,0,1,0,1,0,1, each bit held 4 clocks. tx_done pulses on clock 40 of the frame; busy drops the next cycle.
- cfg_div=0, 8E1, din=0xA7 -> data bits 1,1,1,0,0,1,0,1, then parity 1 and stop 1; 11 clocks total. Repeat with 8O1 -> parity bit 0.
- cfg_data_bits=7, odd parity, cfg_stop2=1, cfg_div=1, din=0xFF -> 7 ones, parity 0, two stop bits; 11 bits x 2 = 22 clocks. cfg_data_bits=3 -> clamped to 5 bits.
- FIFO_DEPTH=4, cfg_div=15, din_valid held high for 8 cycles -> exactly 5 words accepted (one already popped); din_ready low with fifo_level=4. All 5 frames sent back-to-back with no tx-high gap beyond the stop bits; 5 tx_done pulses.
- Change cfg_div and cfg_parity mid-frame -> the current frame keeps the old timing and format; the next frame uses the new settings.
- Assert reset mid-DATA with 3 words queued -> next cycle tx=1, fifo_level=0, din_ready=1, busy=0; no tx_done pulse.
